// File: rtl/d2jk_pkg.sv
// Shared constants for the JK-from-D up/down counter: width bounds and the {J,K} mode encoding.
package d2jk_pkg;
   localparam int WIDTH_DEFAULT = 4;
   localparam int WIDTH_MIN     = 2;
   localparam int WIDTH_MAX     = 8;

   typedef logic [1:0] jk_mode_t;

   // Encoded as {J,K}
   localparam jk_mode_t HOLD   = 2'b00;
   localparam jk_mode_t RESET  = 2'b01;
   localparam jk_mode_t SET    = 2'b10;
   localparam jk_mode_t TOGGLE = 2'b11;

   function automatic jk_mode_t load_mode(input logic d);
      return d ? SET : RESET;
   endfunction
endpackage

// File: rtl/d_2_jk.sv
// One JK flip-flop built from a D flip-flop; Q updates one edge after J/K are sampled.
// Synchronous active-low reset clears Q; Qn is always the complement of Q.
module d_2_jk (
   input  logic clk,
   input  logic rst_n,
   input  logic J,
   input  logic K,
   output logic Q,
   output logic Qn
);
   logic r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) r_q <= 1'b0;
      else        r_q <= (J & ~r_q) | (~K & r_q);
   end

   assign Q  = r_q;
   assign Qn = ~r_q;
endmodule

// File: rtl/d2jk_updown_counter.sv
// Up/down counter with parallel load built from WIDTH JK-from-D bits; q updates one edge after inputs.
// Priority per edge: reset, load, count, hold. tc is purely combinational from en, up and q.
module d2jk_updown_counter
   import d2jk_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             tc
);
   logic [WIDTH-1:0] w_up_all;
   logic [WIDTH-1:0] w_dn_all;
   logic [WIDTH-1:0] w_t;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;

   // Bit i toggles when every lower bit is 1 (up) or 0 (down)
   assign w_up_all[0] = 1'b1;
   assign w_dn_all[0] = 1'b1;

   genvar i;
   for (i = 1; i < WIDTH; i++) begin : g_chain
      assign w_up_all[i] = w_up_all[i-1] &  q[i-1];
      assign w_dn_all[i] = w_dn_all[i-1] & ~q[i-1];
   end

   assign w_t = up ? w_up_all : w_dn_all;

   for (i = 0; i < WIDTH; i++) begin : g_bit
      jk_mode_t w_mode;

      always_comb begin
         w_mode = HOLD;
         if (load)               w_mode = load_mode(din[i]);
         else if (en && w_t[i])  w_mode = TOGGLE;
      end

      assign w_j[i] = w_mode[1];
      assign w_k[i] = w_mode[0];

      d_2_jk u_bit (
         .clk   (clk),
         .rst_n (rst_n),
         .J     (w_j[i]),
         .K     (w_k[i]),
         .Q     (q[i]),
         .Qn    (qn[i])
      );
   end

   assign tc = en & (up ? (&q) : ~(|q));
endmodule

// File: tb/tb_d2jk_updown_counter.sv
// Scoreboard bench: stimulus pushes expected tc/q from an arithmetic model; monitors pop and compare.
module tb_d2jk_updown_counter;
   localparam int W    = 4;
   localparam int MODV = 1 << W;
   localparam int MAXV = MODV - 1;

   logic         clk = 1'b0;
   logic         rst_n, en, up, load;
   logic [W-1:0] din;
   logic [W-1:0] q, qn;
   logic         tc;

   logic b_rst_n, b_j, b_k, b_q, b_qn;

   int checks = 0;
   int errors = 0;
   int q_m    = 0;

   int    exp_tc_q[$];
   int    exp_q_q[$];
   string tag_tc_q[$];
   string tag_q_q[$];

   always #5 clk = ~clk;

   d2jk_updown_counter #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .up    (up),
      .load  (load),
      .din   (din),
      .q     (q),
      .qn    (qn),
      .tc    (tc)
   );

   d_2_jk u_bit (
      .clk   (b_rst_n === 1'bx ? 1'b0 : clk),
      .rst_n (b_rst_n),
      .J     (b_j),
      .K     (b_k),
      .Q     (b_q),
      .Qn    (b_qn)
   );

   // One cycle of stimulus; the model works on plain integers modulo 2^W.
   task automatic step(input logic r, input logic ld, input logic e, input logic u,
                       input int d, input string tag);
      int exp_tc;
      @(negedge clk);
      #1;
      rst_n = r;
      load  = ld;
      en    = e;
      up    = u;
      din   = d[W-1:0];
      exp_tc = (e && ((u && q_m == MAXV) || (!u && q_m == 0))) ? 1 : 0;
      if (!r)      q_m = 0;
      else if (ld) q_m = d % MODV;
      else if (e)  q_m = u ? (q_m + 1) % MODV : (q_m + MAXV) % MODV;
      exp_tc_q.push_back(exp_tc);
      tag_tc_q.push_back(tag);
      exp_q_q.push_back(q_m);
      tag_q_q.push_back(tag);
   endtask

   // tc monitor: inputs settled, just before the next rising edge
   initial begin
      int    e;
      string t;
      forever begin
         @(negedge clk);
         #3;
         if (exp_tc_q.size() > 0) begin
            e = exp_tc_q.pop_front();
            t = tag_tc_q.pop_front();
            checks++;
            if (tc !== e[0]) begin
               errors++;
               $display("FAIL tc[%s] got %b want %0d (q=%h)", t, tc, e, q);
            end
         end
      end
   end

   // q/qn monitor: just after the rising edge that consumed the stimulus
   initial begin
      int           e;
      string        t;
      logic [W-1:0] ev;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q_q.size() > 0) begin
            e  = exp_q_q.pop_front();
            t  = tag_q_q.pop_front();
            ev = e[W-1:0];
            checks++;
            if (q !== ev || qn !== ~ev) begin
               errors++;
               $display("FAIL q[%s] got q=%h qn=%h want q=%h qn=%h", t, q, qn, ev, ~ev);
            end
         end
      end
   end

   initial begin
      logic [1:0] jk_seq [5];
      logic       bq_seq [5];
      int         drain;

      jk_seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
      bq_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      rst_n   = 1'b0;
      en      = 1'b0;
      up      = 1'b0;
      load    = 1'b0;
      din     = '0;
      b_rst_n = 1'b0;
      b_j     = 1'b0;
      b_k     = 1'b0;

      // Standalone JK bit
      @(posedge clk);
      #1;
      checks++;
      if (b_q !== 1'b0 || b_qn !== 1'b1) begin
         errors++;
         $display("FAIL bit_reset got Q=%b Qn=%b want Q=0 Qn=1", b_q, b_qn);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         b_rst_n = 1'b1;
         {b_j, b_k} = jk_seq[k];
         @(posedge clk);
         #1;
         checks++;
         if (b_q !== bq_seq[k] || b_qn !== ~bq_seq[k]) begin
            errors++;
            $display("FAIL bit_jk%0d got Q=%b Qn=%b want Q=%b Qn=%b",
                     k, b_q, b_qn, bq_seq[k], ~bq_seq[k]);
         end
      end

      // Reset beats load; then hold at zero
      step(1'b0, 1'b1, 1'b0, 1'b0, 'hA, "rst0");
      step(1'b0, 1'b1, 1'b0, 1'b0, 'hA, "rst1");
      step(1'b1, 1'b0, 1'b0, 1'b0, 0,   "hold0");
      step(1'b1, 1'b0, 1'b0, 1'b1, 0,   "hold1");

      // Load D, count up through wrap
      step(1'b1, 1'b1, 1'b0, 1'b0, 'hD, "ld_D");
      step(1'b1, 1'b0, 1'b1, 1'b1, 0,   "up_E");
      step(1'b1, 1'b0, 1'b1, 1'b1, 0,   "up_F");
      step(1'b1, 1'b0, 1'b1, 1'b1, 0,   "up_wrap");
      step(1'b1, 1'b0, 1'b0, 1'b1, 0,   "en0_at0");

      // Count down through wrap
      step(1'b1, 1'b0, 1'b1, 1'b0, 0,   "dn_wrap");
      step(1'b1, 1'b0, 1'b1, 1'b0, 0,   "dn_E");
      step(1'b1, 1'b0, 1'b0, 1'b0, 0,   "dn_hold");

      // Load wins over count on the same edge
      step(1'b1, 1'b1, 1'b0, 1'b0, 5,   "ld_5");
      step(1'b1, 1'b1, 1'b1, 1'b1, 2,   "ld_over_cnt");

      // Reset mid-count, then resume from zero
      step(1'b1, 1'b1, 1'b0, 1'b0, 9,   "ld_9");
      step(1'b0, 1'b0, 1'b1, 1'b1, 0,   "rst_mid");
      step(1'b1, 1'b0, 1'b1, 1'b1, 0,   "resume");

      // Randomized traffic, biased toward counting
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 31) != 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0),
              $urandom_range(0, 1),
              int'($urandom_range(0, MAXV)),
              "rand");
      end

      drain = 0;
      while ((exp_q_q.size() > 0 || exp_tc_q.size() > 0) && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      #2;
      if (exp_q_q.size() > 0 || exp_tc_q.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q_q.size() + exp_tc_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
